// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store unit between the CPU datapath and the memory system.
// One transaction in flight at a time; every accepted request produces
// exactly one registered response pulse (data or fault).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_valid/o_req_ready, i_write_en, i_size, i_signed, i_addr, i_data
//                         CPU request (size 0=byte 1=half 2=word 3=dword)
//   o_rsp_valid, o_data, o_fault, o_fault_code
//                         CPU response (code 0 none, 1 misaligned,
//                         2 size unsupported, 3 timeout)
//   o_mem_req_valid/i_mem_req_ready, o_mem_write_en, o_mem_addr,
//   o_mem_wdata, o_mem_wstrb
//                         memory request (lane-steered data and strobes)
//   i_mem_rsp_valid, i_mem_rdata
//                         memory response
module cpu_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_write_en,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic                      o_rsp_valid,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_fault,
    output logic [1:0]                o_fault_code,
    output logic                      o_mem_req_valid,
    input  logic                      i_mem_req_ready,
    output logic                      o_mem_write_en,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb,
    input  logic                      i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_SIZE     = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [OFF_W-1:0]      off_q;
    logic [31:0]           cnt;

    logic                  accept;
    logic [OFF_W-1:0]      req_off;
    logic                  size_bad;
    logic                  misaligned;
    logic [OFF_W-1:0]      align_mask;
    logic [STRB_W-1:0]     strb_base;
    logic [STRB_W-1:0]     req_wstrb;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  sign_bit;
    logic                  mem_done;
    logic                  timeout_hit;

    assign o_req_ready     = (state == ST_IDLE) && !i_rst;
    assign accept          = i_req_valid && o_req_ready;
    assign req_off         = i_addr[OFF_W-1:0];
    assign size_bad        = {30'd0, i_size} > 32'(OFF_W);
    assign misaligned      = |(req_off & align_mask);
    assign req_wstrb       = i_write_en ? (strb_base << req_off) : '0;
    assign req_wdata       = i_data << {req_off, 3'b000};

    assign o_mem_req_valid = (state == ST_REQ);
    assign o_mem_write_en  = we_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wstrb     = wstrb_q;

    // Masks derived from the access size: low offset bits that must be zero,
    // and the unshifted strobe pattern (one bit per byte of the access).
    always_comb begin
        align_mask = '0;
        strb_base  = '0;
        for (int unsigned i = 0; i < OFF_W; i++) begin
            align_mask[i] = (i < 32'(i_size));
        end
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb_base[i] = (i < (32'd1 << i_size));
        end
    end

    // Load lane extraction: bits above the access width take the access's top
    // bit when signed, zero otherwise; a full-width access fills every bit.
    always_comb begin
        rd_shifted = i_mem_rdata >> {off_q, 3'b000};
        sign_bit   = 1'b0;
        load_val   = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i == (32'd8 << size_q) - 32'd1) begin
                sign_bit = rd_shifted[i];
            end
        end
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i < (32'd8 << size_q)) begin
                load_val[i] = rd_shifted[i];
            end else begin
                load_val[i] = signed_q & sign_bit;
            end
        end
    end

    assign mem_done = (state == ST_WAIT) && i_mem_rsp_valid;

    // Fires in the TIMEOUT_CYCLES-th REQ/WAIT cycle; a response arriving in
    // that same cycle takes precedence.
    assign timeout_hit = (TIMEOUT_CYCLES > 0)
                      && ((state == ST_REQ) || (state == ST_WAIT))
                      && (cnt == 32'(TIMEOUT_CYCLES - 1))
                      && !mem_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            off_q        <= '0;
            cnt          <= '0;
            o_rsp_valid  <= 1'b0;
            o_data       <= '0;
            o_fault      <= 1'b0;
            o_fault_code <= FC_NONE;
        end else begin
            o_rsp_valid  <= 1'b0;
            o_data       <= '0;
            o_fault      <= 1'b0;
            o_fault_code <= FC_NONE;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (size_bad) begin
                            o_rsp_valid  <= 1'b1;
                            o_fault      <= 1'b1;
                            o_fault_code <= FC_SIZE;
                        end else if (misaligned) begin
                            o_rsp_valid  <= 1'b1;
                            o_fault      <= 1'b1;
                            o_fault_code <= FC_MISALIGN;
                        end else begin
                            addr_q   <= {i_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                            wdata_q  <= req_wdata;
                            wstrb_q  <= req_wstrb;
                            we_q     <= i_write_en;
                            size_q   <= i_size;
                            signed_q <= i_signed;
                            off_q    <= req_off;
                            cnt      <= '0;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (timeout_hit) begin
                        state        <= ST_IDLE;
                        o_rsp_valid  <= 1'b1;
                        o_fault      <= 1'b1;
                        o_fault_code <= FC_TIMEOUT;
                    end else if (i_mem_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (mem_done) begin
                        state       <= ST_IDLE;
                        o_rsp_valid <= 1'b1;
                        o_data      <= we_q ? '0 : load_val;
                    end else if (timeout_hit) begin
                        state        <= ST_IDLE;
                        o_rsp_valid  <= 1'b1;
                        o_fault      <= 1'b1;
                        o_fault_code <= FC_TIMEOUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// tb_cpu_lsu: directed bench for cpu_lsu with a 32-bit instance (timeout 8)
// and a 64-bit instance (timeout disabled), sharing one clock.
module tb_cpu_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit instance signals
    logic        a_rst = 1'b0, a_req_valid = 1'b0, a_req_ready, a_write_en = 1'b0;
    logic [1:0]  a_size = 2'd0;
    logic        a_signed = 1'b0;
    logic [31:0] a_addr = '0, a_data = '0;
    logic        a_rsp_valid, a_fault;
    logic [31:0] a_rsp_data;
    logic [1:0]  a_fault_code;
    logic        a_mem_req_valid, a_mem_req_ready = 1'b0, a_mem_write_en;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        a_mem_rsp_valid = 1'b0;
    logic [31:0] a_mem_rdata = '0;

    // 64-bit instance signals
    logic        b_rst = 1'b0, b_req_valid = 1'b0, b_req_ready, b_write_en = 1'b0;
    logic [1:0]  b_size = 2'd0;
    logic        b_signed = 1'b0;
    logic [31:0] b_addr = '0;
    logic [63:0] b_data = '0;
    logic        b_rsp_valid, b_fault;
    logic [63:0] b_rsp_data;
    logic [1:0]  b_fault_code;
    logic        b_mem_req_valid, b_mem_req_ready = 1'b0, b_mem_write_en;
    logic [31:0] b_mem_addr;
    logic [63:0] b_mem_wdata;
    logic [7:0]  b_mem_wstrb;
    logic        b_mem_rsp_valid = 1'b0;
    logic [63:0] b_mem_rdata = '0;

    cpu_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut32 (
        .i_clk(clk), .i_rst(a_rst),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_write_en(a_write_en), .i_size(a_size), .i_signed(a_signed),
        .i_addr(a_addr), .i_data(a_data),
        .o_rsp_valid(a_rsp_valid), .o_data(a_rsp_data),
        .o_fault(a_fault), .o_fault_code(a_fault_code),
        .o_mem_req_valid(a_mem_req_valid), .i_mem_req_ready(a_mem_req_ready),
        .o_mem_write_en(a_mem_write_en), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .o_mem_wstrb(a_mem_wstrb),
        .i_mem_rsp_valid(a_mem_rsp_valid), .i_mem_rdata(a_mem_rdata)
    );

    cpu_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) dut64 (
        .i_clk(clk), .i_rst(b_rst),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_write_en(b_write_en), .i_size(b_size), .i_signed(b_signed),
        .i_addr(b_addr), .i_data(b_data),
        .o_rsp_valid(b_rsp_valid), .o_data(b_rsp_data),
        .o_fault(b_fault), .o_fault_code(b_fault_code),
        .o_mem_req_valid(b_mem_req_valid), .i_mem_req_ready(b_mem_req_ready),
        .o_mem_write_en(b_mem_write_en), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .o_mem_wstrb(b_mem_wstrb),
        .i_mem_rsp_valid(b_mem_rsp_valid), .i_mem_rdata(b_mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 32-bit transaction with immediate memory handshakes; returns at T3.
    task automatic txn32(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd);
        a_req_valid = 1'b1; a_write_en = we; a_size = sz; a_signed = sg;
        a_addr = ad; a_data = wd;
        tick();
        a_req_valid = 1'b0; a_mem_req_ready = 1'b1;
        tick();
        a_mem_req_ready = 1'b0; a_mem_rsp_valid = 1'b1; a_mem_rdata = rd;
        tick();
        a_mem_rsp_valid = 1'b0;
    endtask

    task automatic txn64(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [63:0] wd, input logic [63:0] rd);
        b_req_valid = 1'b1; b_write_en = we; b_size = sz; b_signed = sg;
        b_addr = ad; b_data = wd;
        tick();
        b_req_valid = 1'b0; b_mem_req_ready = 1'b1;
        tick();
        b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b1; b_mem_rdata = rd;
        tick();
        b_mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        #1;
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        check("rst_req_ready32", 64'(a_req_ready), 64'd0);
        check("rst_rsp_valid32", 64'(a_rsp_valid), 64'd0);
        check("rst_mem_valid32", 64'(a_mem_req_valid), 64'd0);
        check("rst_fault32", 64'(a_fault), 64'd0);
        check("rst_req_ready64", 64'(b_req_ready), 64'd0);
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        check("idle_req_ready32", 64'(a_req_ready), 64'd1);
        check("idle_req_ready64", 64'(b_req_ready), 64'd1);

        // ---------------- W=32 store byte 0xAB @0x1003 ----------------
        a_req_valid = 1'b1; a_write_en = 1'b1; a_size = 2'd0; a_addr = 32'h1003; a_data = 32'hAB;
        tick();                                    // T1
        a_req_valid = 1'b0;
        check("stb_mem_valid_t1", 64'(a_mem_req_valid), 64'd1);
        check("stb_mem_addr", 64'(a_mem_addr), 64'h1000);
        check("stb_mem_wdata", 64'(a_mem_wdata), 64'hAB000000);
        check("stb_mem_wstrb", 64'(a_mem_wstrb), 64'h8);
        check("stb_mem_we", 64'(a_mem_write_en), 64'd1);
        check("stb_req_ready_t1", 64'(a_req_ready), 64'd0);
        check("stb_rsp_valid_t1", 64'(a_rsp_valid), 64'd0);
        a_mem_req_ready = 1'b1;
        tick();                                    // T2
        a_mem_req_ready = 1'b0;
        check("stb_mem_valid_t2", 64'(a_mem_req_valid), 64'd0);
        check("stb_rsp_valid_t2", 64'(a_rsp_valid), 64'd0);
        a_mem_rsp_valid = 1'b1; a_mem_rdata = 32'hFFFF_FFFF;
        tick();                                    // T3
        a_mem_rsp_valid = 1'b0;
        check("stb_rsp_valid_t3", 64'(a_rsp_valid), 64'd1);
        check("stb_rsp_data", 64'(a_rsp_data), 64'd0);
        check("stb_rsp_fault", 64'(a_fault), 64'd0);
        check("stb_req_ready_t3", 64'(a_req_ready), 64'd1);
        tick();
        check("stb_rsp_valid_t4", 64'(a_rsp_valid), 64'd0);

        // ---------------- W=32 half loads @0x2002 ----------------
        txn32(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234);
        check("lh_signed_valid", 64'(a_rsp_valid), 64'd1);
        check("lh_signed_data", 64'(a_rsp_data), 64'hFFFF8001);
        txn32(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234);
        check("lh_unsigned_data", 64'(a_rsp_data), 64'h00008001);
        txn32(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 32'h0000_7F00);
        check("lb_signed_pos", 64'(a_rsp_data), 64'h0000007F);
        txn32(1'b0, 2'd2, 1'b1, 32'h2000, 32'h0, 32'h8765_4321);
        check("lw_full_ignores_sign", 64'(a_rsp_data), 64'h87654321);
        tick();

        // ---------------- W=32 faults ----------------
        a_req_valid = 1'b1; a_write_en = 1'b0; a_size = 2'd2; a_addr = 32'h3001;
        tick();
        check("mis_word_valid", 64'(a_rsp_valid), 64'd1);
        check("mis_word_fault", 64'(a_fault), 64'd1);
        check("mis_word_code", 64'(a_fault_code), 64'd1);
        check("mis_word_mem_valid", 64'(a_mem_req_valid), 64'd0);
        check("mis_word_data", 64'(a_rsp_data), 64'd0);
        a_size = 2'd3; a_addr = 32'h3000;
        tick();
        check("size_dword_valid", 64'(a_rsp_valid), 64'd1);
        check("size_dword_code", 64'(a_fault_code), 64'd2);
        a_addr = 32'h3001;
        tick();
        check("size_over_align_code", 64'(a_fault_code), 64'd2);
        a_size = 2'd1; a_addr = 32'h2001;
        tick();
        a_req_valid = 1'b0;
        check("mis_half_code", 64'(a_fault_code), 64'd1);
        check("mis_half_mem_valid", 64'(a_mem_req_valid), 64'd0);
        tick();
        check("fault_rsp_clear", 64'(a_rsp_valid), 64'd0);
        check("fault_code_clear", 64'(a_fault_code), 64'd0);

        // ---------------- W=32 request held off 5 cycles ----------------
        a_req_valid = 1'b1; a_write_en = 1'b1; a_size = 2'd2; a_addr = 32'h4000; a_data = 32'hDEAD_BEEF;
        tick();
        a_req_valid = 1'b0; a_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("hold_mem_valid", 64'(a_mem_req_valid), 64'd1);
            check("hold_mem_addr", 64'(a_mem_addr), 64'h4000);
            check("hold_mem_wdata", 64'(a_mem_wdata), 64'hDEADBEEF);
            check("hold_mem_wstrb", 64'(a_mem_wstrb), 64'hF);
            tick();
        end
        check("hold_mem_valid_6", 64'(a_mem_req_valid), 64'd1);
        a_mem_req_ready = 1'b1;
        tick();
        a_mem_req_ready = 1'b0;
        check("hold_accepted", 64'(a_mem_req_valid), 64'd0);
        a_mem_rsp_valid = 1'b1;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("hold_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("hold_rsp_fault", 64'(a_fault), 64'd0);

        // ---------------- W=32 timeout in WAIT ----------------
        a_req_valid = 1'b1; a_write_en = 1'b0; a_size = 2'd2; a_addr = 32'h5000;
        tick();                                    // REQ/WAIT cycle 1
        a_req_valid = 1'b0; a_mem_req_ready = 1'b1;
        tick();                                    // cycle 2
        a_mem_req_ready = 1'b0;
        repeat (6) tick();                         // cycle 8
        check("to_no_early_rsp", 64'(a_rsp_valid), 64'd0);
        tick();
        check("to_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("to_fault", 64'(a_fault), 64'd1);
        check("to_code", 64'(a_fault_code), 64'd3);
        check("to_data", 64'(a_rsp_data), 64'd0);
        check("to_req_ready", 64'(a_req_ready), 64'd1);
        a_mem_rsp_valid = 1'b1; a_mem_rdata = 32'hFFFF_FFFF;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("stray_rsp_ignored", 64'(a_rsp_valid), 64'd0);
        check("stray_mem_valid", 64'(a_mem_req_valid), 64'd0);

        // ---------------- W=32 timeout while request never accepted ----------------
        a_req_valid = 1'b1; a_addr = 32'h5004;
        tick();                                    // cycle 1
        a_req_valid = 1'b0;
        repeat (7) tick();                         // cycle 8
        check("to_req_mem_valid_8", 64'(a_mem_req_valid), 64'd1);
        tick();
        check("to_req_mem_dropped", 64'(a_mem_req_valid), 64'd0);
        check("to_req_code", 64'(a_fault_code), 64'd3);

        // ---------------- W=32 response in the 8th cycle wins ----------------
        a_req_valid = 1'b1; a_addr = 32'h6000;
        tick();                                    // cycle 1
        a_req_valid = 1'b0; a_mem_req_ready = 1'b1;
        tick();                                    // cycle 2
        a_mem_req_ready = 1'b0;
        repeat (6) tick();                         // cycle 8
        a_mem_rsp_valid = 1'b1; a_mem_rdata = 32'h1234_5678;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("late_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("late_rsp_fault", 64'(a_fault), 64'd0);
        check("late_rsp_code", 64'(a_fault_code), 64'd0);
        check("late_rsp_data", 64'(a_rsp_data), 64'h12345678);

        // ---------------- W=64 dword then back-to-back byte ----------------
        b_req_valid = 1'b1; b_write_en = 1'b0; b_size = 2'd3; b_signed = 1'b1; b_addr = 32'h10;
        tick();
        b_req_valid = 1'b0;
        check("d64_mem_addr", 64'(b_mem_addr), 64'h10);
        check("d64_load_wstrb", 64'(b_mem_wstrb), 64'h0);
        check("d64_mem_we", 64'(b_mem_write_en), 64'd0);
        b_mem_req_ready = 1'b1;
        tick();
        b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b1; b_mem_rdata = 64'hF123_4567_89AB_CDEF;
        tick();
        b_mem_rsp_valid = 1'b0;
        check("d64_rsp_valid", 64'(b_rsp_valid), 64'd1);
        check("d64_rsp_data", b_rsp_data, 64'hF123456789ABCDEF);
        check("d64_req_ready", 64'(b_req_ready), 64'd1);
        b_req_valid = 1'b1; b_size = 2'd0; b_signed = 1'b0; b_addr = 32'h17;
        tick();
        b_req_valid = 1'b0;
        check("b64_rsp_cleared", 64'(b_rsp_valid), 64'd0);
        check("b64_mem_valid", 64'(b_mem_req_valid), 64'd1);
        check("b64_mem_addr", 64'(b_mem_addr), 64'h10);
        b_mem_req_ready = 1'b1;
        tick();
        b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b1; b_mem_rdata = 64'hA511_2233_4455_6677;
        tick();
        b_mem_rsp_valid = 1'b0;
        check("b64_rsp_valid", 64'(b_rsp_valid), 64'd1);
        check("b64_rsp_data", b_rsp_data, 64'h00000000000000A5);

        // ---------------- W=64 store half @0x16 ----------------
        b_req_valid = 1'b1; b_write_en = 1'b1; b_size = 2'd1; b_addr = 32'h16; b_data = 64'hBEEF;
        tick();
        b_req_valid = 1'b0;
        check("sh64_wdata", b_mem_wdata, 64'hBEEF000000000000);
        check("sh64_wstrb", 64'(b_mem_wstrb), 64'hC0);
        b_mem_req_ready = 1'b1;
        tick();
        b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b1;
        tick();
        b_mem_rsp_valid = 1'b0;
        check("sh64_rsp_data", b_rsp_data, 64'd0);

        // ---------------- W=64 signed word @0x24, misaligned word @0x22 ----------------
        txn64(1'b0, 2'd2, 1'b1, 32'h24, 64'h0, 64'h8000_0000_0000_0000);
        check("lw64_signed", b_rsp_data, 64'hFFFFFFFF80000000);
        b_req_valid = 1'b1; b_write_en = 1'b0; b_size = 2'd2; b_addr = 32'h22;
        tick();
        b_req_valid = 1'b0;
        check("mis64_code", 64'(b_fault_code), 64'd1);

        // ---------------- W=64 reset pulse in WAIT ----------------
        b_req_valid = 1'b1; b_size = 2'd2; b_signed = 1'b0; b_addr = 32'h20;
        tick();
        b_req_valid = 1'b0; b_mem_req_ready = 1'b1;
        tick();                                    // WAIT
        b_mem_req_ready = 1'b0;
        b_rst = 1'b1; b_mem_rsp_valid = 1'b1; b_mem_rdata = 64'h1;
        #1;
        check("rstw_req_ready", 64'(b_req_ready), 64'd0);
        check("rstw_mem_valid", 64'(b_mem_req_valid), 64'd0);
        tick();
        check("rstw_no_rsp", 64'(b_rsp_valid), 64'd0);
        b_rst = 1'b0; b_mem_rsp_valid = 1'b0;
        tick();
        check("rstw_no_rsp_after", 64'(b_rsp_valid), 64'd0);
        check("rstw_idle_ready", 64'(b_req_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
